// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared constants and arbitration type for the RAM-backed FIFO
package ram_fifo_pkg;

  localparam int RD_LAT     = 1;
  localparam int OBUF_DEPTH = 2;

  typedef enum logic {
    ARB_WR = 1'b0,
    ARB_RD = 1'b1
  } arb_e;

endpackage

// File: rtl/ram_4x4.sv
// rtl/ram_4x4.sv - single-port synchronous RAM, one access per cycle, read latency 1
module ram_4x4 #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  input  logic          en,
  input  logic          wr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [1 << AW];

  // Write stores d; a read registers the addressed word onto q at the same edge
  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) mem[a] <= d;
      else    q      <= mem[a];
    end
  end

endmodule

// File: rtl/ram_fifo_obuf.sv
// rtl/ram_fifo_obuf.sv - two-entry output buffer fed by RAM read data
module ram_fifo_obuf
  import ram_fifo_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [DW-1:0] push_d,
  output logic          pop_vld,
  output logic [DW-1:0] pop_d,
  input  logic          pop_rdy,
  output logic [1:0]    occ
);

  logic [DW-1:0] mem [OBUF_DEPTH];
  logic          wr_idx;
  logic          rd_idx;
  logic          pop_fire;

  assign pop_vld  = (occ != 2'd0);
  assign pop_fire = pop_vld && pop_rdy;
  // Gate data so stale entries never show up while the buffer is empty
  assign pop_d    = pop_vld ? mem[rd_idx] : '0;

  // Ring of two entries; the controller never pushes into a full buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push_vld) begin
        mem[wr_idx] <= push_d;
        wr_idx      <= ~wr_idx;
      end
      if (pop_fire) rd_idx <= ~rd_idx;
      occ <= occ + 2'(push_vld) - 2'(pop_fire);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller storing words in an external RAM plus output buffer
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [DW-1:0] push_d,
  output logic          push_rdy,
  output logic          pop_vld,
  output logic [DW-1:0] pop_d,
  input  logic          pop_rdy,
  output logic [AW+1:0] count,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_en,
  output logic          ram_wr,
  input  logic [DW-1:0] ram_q
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] CAP_C   = (AW+2)'(DEPTH + OBUF_DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   ram_cnt;
  logic          rd_inflight;
  arb_e          rr;
  logic          active;
  logic [1:0]    occ;

  logic rd_cond;
  logic wr_room;
  logic do_wr;
  logic do_rd;
  logic contested;

  // A read is worth issuing only if the output buffer can absorb its data
  assign rd_cond   = (ram_cnt != '0) && ((occ + {1'b0, rd_inflight}) < 2'(OBUF_DEPTH));
  assign wr_room   = (ram_cnt < DEPTH_C);
  // active holds push_rdy low during reset and the first edge after release
  assign push_rdy  = active && wr_room && !(rd_cond && (rr == ARB_RD));
  assign do_wr     = push_vld && push_rdy;
  assign do_rd     = rd_cond && !do_wr;
  assign contested = active && rd_cond && push_vld && wr_room;

  assign ram_en = do_wr || do_rd;
  assign ram_wr = do_wr;
  assign ram_a  = do_wr ? wptr : (do_rd ? rptr : '0);
  assign ram_d  = do_wr ? push_d : '0;

  assign count = {1'b0, ram_cnt} + (AW+2)'(rd_inflight) + (AW+2)'(occ);
  assign empty = (count == '0);
  assign full  = (count == CAP_C);

  // Pointers, RAM occupancy, read pipeline and round-robin flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      rr          <= ARB_WR;
      active      <= 1'b0;
    end else begin
      active <= 1'b1;
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      ram_cnt     <= ram_cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      rd_inflight <= do_rd;
      if (contested) rr <= (rr == ARB_WR) ? ARB_RD : ARB_WR;
    end
  end

  ram_fifo_obuf #(
    .DW (DW)
  ) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (rd_inflight),
    .push_d   (ram_q),
    .pop_vld  (pop_vld),
    .pop_d    (pop_d),
    .pop_rdy  (pop_rdy),
    .occ      (occ)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - directed self-checking bench for ram_fifo_ctrl with ram_4x4
module tb_ram_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          push_vld = 1'b0;
  logic [DW-1:0] push_d = '0;
  logic          push_rdy;
  logic          pop_vld;
  logic [DW-1:0] pop_d;
  logic          pop_rdy = 1'b0;
  logic [AW+1:0] count;
  logic          full;
  logic          empty;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_en;
  logic          ram_wr;
  logic [DW-1:0] ram_q;

  int n_run  = 0;
  int n_fail = 0;
  int q[$];
  int npop;
  int wa_exp, ra_exp;
  bit wa_have, ra_have;
  int wa_err, ra_err, wa_wraps, ra_wraps;

  ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_d   (push_d),
    .push_rdy (push_rdy),
    .pop_vld  (pop_vld),
    .pop_d    (pop_d),
    .pop_rdy  (pop_rdy),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ram_a    (ram_a),
    .ram_d    (ram_d),
    .ram_en   (ram_en),
    .ram_wr   (ram_wr),
    .ram_q    (ram_q)
  );

  ram_4x4 #(.AW(AW), .DW(DW)) u_ram (
    .clk (clk),
    .a   (ram_a),
    .d   (ram_d),
    .en  (ram_en),
    .wr  (ram_wr),
    .q   (ram_q)
  );

  always #15 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: entered and left at posedge+1, handshakes sampled mid-cycle
  task automatic step();
    #1;
    if (pop_vld && pop_rdy) begin
      npop++;
      if (q.size() == 0) chk("pop_extra", 1, 0);
      else chk("pop_order", int'(pop_d), q.pop_front());
    end
    if (push_vld && push_rdy) q.push_back(int'(push_d));
    if (ram_en && ram_wr) begin
      if (wa_have && int'(ram_a) != wa_exp) wa_err++;
      if (wa_have && ram_a == 0 && wa_exp == 0) wa_wraps++;
      wa_exp  = (int'(ram_a) + 1) % 16;
      wa_have = 1'b1;
    end
    if (ram_en && !ram_wr) begin
      if (ra_have && int'(ram_a) != ra_exp) ra_err++;
      if (ra_have && ram_a == 0 && ra_exp == 0) ra_wraps++;
      ra_exp  = (int'(ram_a) + 1) % 16;
      ra_have = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int d);
    bit acc;
    acc = 1'b0;
    push_vld = 1'b1;
    push_d   = d[DW-1:0];
    for (int k = 0; k < 40; k++) begin
      #1;
      acc = push_rdy;
      step();
      if (acc) break;
    end
    if (!acc) chk("push_timeout", 0, 1);
    push_vld = 1'b0;
  endtask

  task automatic drain(input string tag, input int exp_pops);
    npop     = 0;
    push_vld = 1'b0;
    pop_rdy  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (empty) break;
      step();
    end
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_pops"}, npop, exp_pops);
    chk({tag, "_sb_left"}, q.size(), 0);
    pop_rdy = 1'b0;
  endtask

  initial begin
    int nextval;
    bit acc;
    bit seen;
    int alt_err;
    bit en_h[20];
    bit wr_h[20];

    // reset values, checked without any clock edge
    #2 rst_n = 1'b0;
    #3;
    chk("rst_push_rdy", int'(push_rdy), 0);
    chk("rst_pop_vld", int'(pop_vld), 0);
    chk("rst_pop_d", int'(pop_d), 0);
    chk("rst_ram_en", int'(ram_en), 0);
    chk("rst_ram_wr", int'(ram_wr), 0);
    chk("rst_ram_a", int'(ram_a), 0);
    chk("rst_ram_d", int'(ram_d), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    step();

    // latency on an idle block, then fill with 3..12 and drain
    pop_rdy  = 1'b0;
    push_vld = 1'b1;
    push_d   = 4'd3;
    step();
    push_vld = 1'b0;
    #1;
    chk("lat_rd_en", int'(ram_en), 1);
    chk("lat_rd_wr", int'(ram_wr), 0);
    chk("lat_rd_a", int'(ram_a), 0);
    chk("lat_vld_n1", int'(pop_vld), 0);
    step();
    chk("lat_vld_n2", int'(pop_vld), 0);
    step();
    chk("lat_vld_n3", int'(pop_vld), 1);
    chk("lat_pop_d", int'(pop_d), 3);
    for (int v = 4; v <= 12; v++) push_word(v);
    repeat (6) step();
    chk("fill_count", int'(count), 10);
    chk("fill_vld", int'(pop_vld), 1);
    chk("fill_head", int'(pop_d), 3);
    chk("fill_empty", int'(empty), 0);
    drain("fill", 10);
    chk("fill_count0", int'(count), 0);

    // empty pop: no RAM activity, nothing valid
    pop_rdy = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      seen = seen | ram_en | pop_vld;
      step();
    end
    chk("empty_pop_activity", int'(seen), 0);
    pop_rdy = 1'b0;

    // full: 18 words fit, the 19th is refused
    for (int v = 0; v < 18; v++) push_word((v + 5) % 16);
    repeat (4) step();
    chk("full_flag", int'(full), 1);
    chk("full_push_rdy", int'(push_rdy), 0);
    chk("full_count", int'(count), 18);
    push_vld = 1'b1;
    push_d   = 4'd15;
    repeat (3) step();
    push_vld = 1'b0;
    chk("full_19th_count", int'(count), 18);
    drain("full", 18);

    // contention: 8 words in RAM, continuous push and pop
    for (int v = 0; v < 10; v++) push_word(v);
    repeat (4) step();
    chk("cont_pre_count", int'(count), 10);
    nextval = 10;
    pop_rdy = 1'b1;
    push_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_d = 4'(nextval);
      #1;
      en_h[i] = ram_en;
      wr_h[i] = ram_wr;
      acc = push_rdy;
      step();
      if (acc) nextval++;
    end
    push_vld = 1'b0;
    alt_err = 0;
    for (int i = 2; i < 20; i++)
      if (!en_h[i] || (wr_h[i] == wr_h[i-1])) alt_err++;
    chk("cont_alternate_errs", alt_err, 0);
    drain("cont", q.size());

    // wrap: stream 40 words through with the consumer always ready
    wa_err = 0; ra_err = 0; wa_wraps = 0; ra_wraps = 0;
    nextval = 0;
    npop = 0;
    pop_rdy = 1'b1;
    push_vld = 1'b1;
    for (int k = 0; k < 400 && nextval < 40; k++) begin
      push_d = 4'(nextval % 16);
      #1;
      acc = push_rdy;
      step();
      if (acc) nextval++;
    end
    push_vld = 1'b0;
    chk("wrap_sent", nextval, 40);
    for (int k = 0; k < 50 && !empty; k++) step();
    chk("wrap_pops", npop, 40);
    chk("wrap_sb_left", q.size(), 0);
    chk("wrap_wa_err", wa_err, 0);
    chk("wrap_ra_err", ra_err, 0);
    chk("wrap_wr_seen", int'(wa_wraps > 0), 1);
    chk("wrap_rd_seen", int'(ra_wraps > 0), 1);
    pop_rdy = 1'b0;

    // reset mid-run with 5 entries stored and one read in flight
    for (int v = 0; v < 6; v++) push_word(v);
    repeat (4) step();
    npop = 0;
    pop_rdy = 1'b1;
    step();
    pop_rdy = 1'b0;
    chk("mid_pop1", npop, 1);
    #1;
    chk("mid_rd_cmd", int'(ram_en && !ram_wr), 1);
    step();
    chk("mid_count5", int'(count), 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", int'(pop_vld), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_pop_d", int'(pop_d), 0);
    q.delete();
    wa_have = 1'b0;
    ra_have = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    for (int v = 10; v < 14; v++) push_word(v);
    drain("post_rst", 4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter: AW, 4, RAM address width (RAM depth 2**AW).
REQ-002 The block SHALL have parameter: DW, 4, data width.
REQ-003 The block SHALL have port: CLK  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port: RSTN  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports: PUSH_VLD input 1, PUSH_D input DW, PUSH_RDY output 1; upstream write handshake.
REQ-006 The block SHALL have ports: POP_VLD output 1, POP_D output DW, POP_RDY input 1; downstream read handshake.
REQ-007 The block SHALL have ports: COUNT output AW+2 (total stored entries), FULL output 1, EMPTY output 1.
REQ-008 The block SHALL have RAM-side ports: RAM_A output AW, RAM_D output DW, RAM_EN output 1, RAM_WR output 1 (1 write, 0 read), RAM_Q input DW; these connect directly to the A/D/EN/WR/Q ports of ram_4x4.

Function
REQ-009 Transfer SHALL occur on a rising CLK edge where VLD and RDY are both 1; PUSH_RDY and POP_VLD SHALL depend only on registered state.
REQ-010 Storage SHALL be the external RAM (2**AW words) plus a 2-entry output buffer; capacity = 2**AW+2.
REQ-011 At most one RAM access per cycle; RAM_EN=1 only in a cycle carrying a write or a read command, otherwise RAM_EN=0, RAM_WR=0.
REQ-012 Write command: issued in the cycle of an accepted push; RAM_A=wptr, RAM_D=PUSH_D, RAM_WR=1; wptr increments modulo 2**AW.
REQ-013 Read request condition: ram_cnt>0 and (obuf occupancy + reads in flight) < 2.
REQ-014 Read command: RAM_A=rptr, RAM_WR=0, RAM_EN=1; rptr increments modulo 2**AW; RAM_Q SHALL be captured into obuf on the rising edge one cycle after the edge that sampled the read command (read latency 1).
REQ-015 Arbitration: when read condition and PUSH_VLD both hold with ram_cnt<2**AW, a round-robin flag selects; the flag toggles after every contested cycle; otherwise the sole requester wins.
REQ-016 PUSH_RDY = (ram_cnt < 2**AW) and not (read condition and flag selects read).
REQ-017 obuf SHALL present its oldest entry on POP_D with POP_VLD=1; FIFO order SHALL be preserved end to end.
REQ-018 Latency: push accepted at edge n on an idle empty block -> read command cycle n+1 -> POP_VLD=1 from cycle after edge n+2.
REQ-019 COUNT = ram_cnt + in-flight reads + obuf occupancy; EMPTY = (COUNT==0); FULL = (COUNT==2**AW+2).
REQ-020 Simultaneous push and pop in one cycle SHALL both complete; COUNT unchanged.
REQ-021 Pop when POP_VLD=0 and push when PUSH_RDY=0 SHALL have no effect.
REQ-022 Pointer wrap 2**AW-1 -> 0 SHALL be seamless with no lost or duplicated word.

Reset
REQ-023 RSTN low SHALL immediately clear wptr, rptr, ram_cnt, in-flight flag, obuf, round-robin flag (write-first).
REQ-024 During reset: PUSH_RDY=0, POP_VLD=0, POP_D=0, RAM_EN=0, RAM_WR=0, RAM_A=0, RAM_D=0, COUNT=0, EMPTY=1, FULL=0.
REQ-025 A read in flight at reset SHALL be discarded; RAM contents are not cleared and SHALL never reappear at POP_D.

Structure
REQ-026 Package ram_fifo_pkg SHALL hold RD_LAT=1, OBUF_DEPTH=2 and the arbitration enum {ARB_WR, ARB_RD}.
REQ-027 The 2-entry output buffer SHALL be sub-module ram_fifo_obuf (push from RAM_Q, pop to POP_*, occupancy output).

Verification (bench instantiates ram_fifo_ctrl + ram_4x4, AW=4, DW=4, CLK period 30 ns)
REQ-028 Fill/drain: push 3..12 with POP_RDY=0 -> COUNT=10, POP_VLD=1 after cycle n+2; then POP_RDY=1 -> POP_D sequence 3..12, EMPTY=1.
REQ-029 Full: push 18 words, POP_RDY=0 -> FULL=1, PUSH_RDY=0, 19th word not accepted, COUNT=18.
REQ-030 Contention: RAM holding 8 words, PUSH_VLD=1 and POP_RDY=1 continuously -> RAM_WR alternates 1/0 on contested cycles, order preserved.
REQ-031 Wrap: stream 40 words 0..39 mod 16 -> RAM_A wraps 15->0, output equals input order, no gaps.
REQ-032 Reset mid-run: 5 entries stored, one read in flight, RSTN=0 -> POP_VLD=0, COUNT=0, EMPTY=1 without a clock edge; after release, first pop returns only newly pushed data.
REQ-033 Empty pop: POP_RDY=1, no push -> RAM_EN stays 0, POP_VLD stays 0.
